// File: rtl/zx_mem_pkg.sv
// Shared constants and types for the Spectrum paging unit: port decode
// masks, the +3 all-RAM page table and page/bank typedefs.
package zx_mem_pkg;

  localparam logic [15:0] K128_7FFD_MASK = 16'h8002;
  localparam logic [15:0] K128_7FFD_VAL  = 16'h0000;
  localparam logic [15:0] P3_7FFD_MASK   = 16'hC002;
  localparam logic [15:0] P3_7FFD_VAL    = 16'h4000;
  localparam logic [15:0] P3_1FFD_MASK   = 16'hF002;
  localparam logic [15:0] P3_1FFD_VAL    = 16'h1000;

  localparam int MAX_PW = 5;

  typedef logic [MAX_PW-1:0] page_t;
  typedef logic [1:0]        bank_t;
  typedef logic [1:0]        slot_t;

  // Rows are 1FFD[2:1], columns are the 16K slot.
  localparam page_t SPECIAL_MAP [4][4] = '{
    '{5'd0, 5'd1, 5'd2, 5'd3},
    '{5'd4, 5'd5, 5'd6, 5'd7},
    '{5'd4, 5'd5, 5'd6, 5'd3},
    '{5'd4, 5'd7, 5'd6, 5'd3}
  };

  function automatic bit ram_pages_ok(input int n);
    return (n == 8) || (n == 16) || (n == 32);
  endfunction

  // Illegal page counts fall back to the plain 128K width.
  function automatic int page_bits(input int n);
    if (!ram_pages_ok(n)) return 3;
    return (n == 32) ? 5 : ((n == 16) ? 4 : 3);
  endfunction

endpackage

// File: rtl/zx_port_snoop.sv
// Snoops Z80 OUT cycles to the 7FFD/1FFD paging ports and holds the paging
// registers and lock bit; updates once per OUT cycle on the strobe's first edge.
module zx_port_snoop
  import zx_mem_pkg::*;
#(
  parameter int PLUS3 = 0
) (
  input  logic        clk_cpu,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic [7:0]  din,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  output logic [7:0]  reg_7ffd,
  output logic [7:0]  reg_1ffd,
  output logic        paging_locked
);

  logic io_we;
  logic io_we_d;
  logic fire;
  logic hit_7ffd;
  logic hit_1ffd;

  // nM1 high excludes interrupt-acknowledge cycles, which also assert nIORQ.
  assign io_we = !nIORQ && !nWR && nRD && nM1;
  assign fire  = io_we && !io_we_d && !paging_locked;

  assign hit_7ffd = (PLUS3 != 0) ? ((A & P3_7FFD_MASK) == P3_7FFD_VAL)
                                 : ((A & K128_7FFD_MASK) == K128_7FFD_VAL);
  assign hit_1ffd = (PLUS3 != 0) && ((A & P3_1FFD_MASK) == P3_1FFD_VAL);

  always_ff @(posedge clk_cpu or negedge nRESET) begin
    if (!nRESET) begin
      io_we_d       <= 1'b0;
      reg_7ffd      <= 8'h00;
      reg_1ffd      <= 8'h00;
      paging_locked <= 1'b0;
    end else begin
      io_we_d <= io_we;
      if (fire && hit_7ffd) begin
        reg_7ffd      <= din;
        paging_locked <= din[5];
      end
      if (fire && hit_1ffd) begin
        reg_1ffd <= din;
      end
    end
  end

endmodule

// File: rtl/zx_mem_mapper.sv
// 128K/+2A/+3 memory paging unit: translates each CPU memory cycle into a
// physical SDRAM address, ROM flag, strobes and screen-VRAM write port.
module zx_mem_mapper
  import zx_mem_pkg::*;
#(
  parameter int              RAM_PAGES = 8,
  parameter int              PLUS3     = 0,
  parameter int              ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] RAM_BASE = '0,
  parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(32'h0100000)
) (
  input  logic              clk_cpu,
  input  logic              nRESET,
  input  logic [15:0]       A,
  input  logic [7:0]        din,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  input  logic              nM1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rom,
  output logic              mem_we,
  output logic              mem_rd,
  output logic              vram_we,
  output logic [13:0]       vram_addr,
  output logic              shadow_scr,
  output logic [7:0]        reg_7ffd,
  output logic [7:0]        reg_1ffd,
  output logic              paging_locked
);

  localparam int PW = page_bits(RAM_PAGES);

  page_t             page;
  page_t             slot3_page;
  bank_t             rom_bank;
  logic              special;
  logic              page7;
  logic [ADDR_W-1:0] ram_off;
  logic [ADDR_W-1:0] rom_off;

  zx_port_snoop #(
    .PLUS3 (PLUS3)
  ) u_snoop (
    .clk_cpu       (clk_cpu),
    .nRESET        (nRESET),
    .A             (A),
    .din           (din),
    .nIORQ         (nIORQ),
    .nRD           (nRD),
    .nWR           (nWR),
    .nM1           (nM1),
    .reg_7ffd      (reg_7ffd),
    .reg_1ffd      (reg_1ffd),
    .paging_locked (paging_locked)
  );

  // Extended RAM borrows 7FFD[7:6] as upper page bits on larger boards.
  if (PW == 5) begin : g_pages32
    assign slot3_page = {reg_7ffd[7:6], reg_7ffd[2:0]};
  end else if (PW == 4) begin : g_pages16
    assign slot3_page = {1'b0, reg_7ffd[6], reg_7ffd[2:0]};
  end else begin : g_pages8
    assign slot3_page = {2'b00, reg_7ffd[2:0]};
  end

  if (PLUS3 != 0) begin : g_plus3_bank
    assign rom_bank = {reg_1ffd[2], reg_7ffd[4]};
  end else begin : g_128k_bank
    assign rom_bank = {1'b0, reg_7ffd[4]};
  end

  assign special = (PLUS3 != 0) && reg_1ffd[0];

  always_comb begin
    page    = '0;
    mem_rom = 1'b0;
    if (special) begin
      page = SPECIAL_MAP[reg_1ffd[2:1]][A[15:14]];
    end else begin
      unique case (A[15:14])
        2'd0:    mem_rom = 1'b1;
        2'd1:    page    = 5'd5;
        2'd2:    page    = 5'd2;
        default: page    = slot3_page;
      endcase
    end
  end

  assign ram_off  = ADDR_W'({page, A[13:0]});
  assign rom_off  = ADDR_W'({rom_bank, A[13:0]});
  assign mem_addr = mem_rom ? (ROM_BASE + rom_off) : (RAM_BASE + ram_off);

  assign mem_rd = !nMREQ && !nRD;
  assign mem_we = !nMREQ && !nWR && nRD && !mem_rom;

  // Only the lower 8K of pages 5 and 7 hold displayable screen data.
  assign page7     = !mem_rom && (page == 5'd7);
  assign vram_we   = mem_we && ((page == 5'd5) || (page == 5'd7)) && !A[13];
  assign vram_addr = {page7, A[12:0]};

  assign shadow_scr = reg_7ffd[3];

endmodule

// File: tb/tb_zx_mem_mapper.sv
// Bench for zx_mem_mapper: three configurations share one Z80 bus and are
// compared against a slot/page reference model and a fixed vector table.
module tb_zx_mem_mapper;

  logic        clk_cpu;
  logic        nRESET;
  logic [15:0] A;
  logic [7:0]  din;
  logic        nMREQ, nIORQ, nRD, nWR, nM1;

  logic [24:0] mem_addr_o  [3];
  logic        mem_rom_o   [3];
  logic        mem_we_o    [3];
  logic        mem_rd_o    [3];
  logic        vram_we_o   [3];
  logic [13:0] vram_addr_o [3];
  logic        shadow_o    [3];
  logic [7:0]  r7_o        [3];
  logic [7:0]  r1_o        [3];
  logic        lock_o      [3];

  int          cfg_pages [3] = '{8, 32, 16};
  int          cfg_p3    [3] = '{0, 1, 1};
  logic [24:0] cfg_ram   [3] = '{25'h0000000, 25'h0000000, 25'h0400000};
  logic [24:0] cfg_rom   [3] = '{25'h0100000, 25'h0100000, 25'h0080000};
  int          spec_tab  [4][4] = '{'{0,1,2,3}, '{4,5,6,7}, '{4,5,6,3}, '{4,7,6,3}};

  logic [7:0]  m7   [3];
  logic [7:0]  m1   [3];
  logic        mlock[3];

  int n_tests = 0;
  int n_fail  = 0;

  zx_mem_mapper u_a (
    .clk_cpu(clk_cpu), .nRESET(nRESET), .A(A), .din(din),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .mem_addr(mem_addr_o[0]), .mem_rom(mem_rom_o[0]), .mem_we(mem_we_o[0]),
    .mem_rd(mem_rd_o[0]), .vram_we(vram_we_o[0]), .vram_addr(vram_addr_o[0]),
    .shadow_scr(shadow_o[0]), .reg_7ffd(r7_o[0]), .reg_1ffd(r1_o[0]),
    .paging_locked(lock_o[0])
  );

  zx_mem_mapper #(.RAM_PAGES(32), .PLUS3(1)) u_b (
    .clk_cpu(clk_cpu), .nRESET(nRESET), .A(A), .din(din),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .mem_addr(mem_addr_o[1]), .mem_rom(mem_rom_o[1]), .mem_we(mem_we_o[1]),
    .mem_rd(mem_rd_o[1]), .vram_we(vram_we_o[1]), .vram_addr(vram_addr_o[1]),
    .shadow_scr(shadow_o[1]), .reg_7ffd(r7_o[1]), .reg_1ffd(r1_o[1]),
    .paging_locked(lock_o[1])
  );

  zx_mem_mapper #(.RAM_PAGES(16), .PLUS3(1), .RAM_BASE(25'h0400000),
                  .ROM_BASE(25'h0080000)) u_c (
    .clk_cpu(clk_cpu), .nRESET(nRESET), .A(A), .din(din),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .mem_addr(mem_addr_o[2]), .mem_rom(mem_rom_o[2]), .mem_we(mem_we_o[2]),
    .mem_rd(mem_rd_o[2]), .vram_we(vram_we_o[2]), .vram_addr(vram_addr_o[2]),
    .shadow_scr(shadow_o[2]), .reg_7ffd(r7_o[2]), .reg_1ffd(r1_o[2]),
    .paging_locked(lock_o[2])
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  typedef struct {
    logic [24:0] addr;
    logic        rom, we, rd, vwe;
    logic [13:0] vaddr;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    int          kind;
    logic [24:0] addr;
    logic        rom, we, rd, vwe;
    logic [13:0] vaddr;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int c, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d A=%h got=%h exp=%h", name, c, A, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      m7[c] = 8'h00; m1[c] = 8'h00; mlock[c] = 1'b0;
    end
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    int ai;
    ai = int'(a);
    for (int c = 0; c < 3; c++) begin
      if (!mlock[c]) begin
        if (cfg_p3[c] != 0) begin
          if ((ai / 16384) == 1 && a[1] == 1'b0) begin
            m7[c] = d; mlock[c] = d[5];
          end else if ((ai / 4096) == 1 && a[1] == 1'b0) begin
            m1[c] = d;
          end
        end else if (ai < 32768 && a[1] == 1'b0) begin
          m7[c] = d; mlock[c] = d[5];
        end
      end
    end
  endfunction

  function automatic exp_t model_map(input int c);
    exp_t e;
    int slot, off, page, bank;
    bit rom;
    slot = int'(A) / 16384;
    off  = int'(A) % 16384;
    page = 0; bank = 0; rom = 1'b0;
    if (cfg_p3[c] != 0 && m1[c][0]) begin
      page = spec_tab[int'(m1[c][2:1])][slot];
    end else if (slot == 0) begin
      rom  = 1'b1;
      bank = int'(m7[c][4]) + ((cfg_p3[c] != 0) ? 2 * int'(m1[c][2]) : 0);
    end else if (slot == 1) begin
      page = 5;
    end else if (slot == 2) begin
      page = 2;
    end else begin
      page = int'(m7[c]) % 8;
      if (cfg_pages[c] >= 16) page += 8 * int'(m7[c][6]);
      if (cfg_pages[c] == 32) page += 16 * int'(m7[c][7]);
    end
    e.rom  = rom;
    e.addr = rom ? 25'(int'(cfg_rom[c]) + bank * 16384 + off)
                 : 25'(int'(cfg_ram[c]) + page * 16384 + off);
    e.rd   = !nMREQ && !nRD;
    e.we   = !nMREQ && !nWR && nRD && !rom;
    e.vwe  = e.we && (page == 5 || page == 7) && (off < 8192);
    e.vaddr = 14'(((!rom && page == 7) ? 8192 : 0) + off % 8192);
    return e;
  endfunction

  task automatic check_all();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      e = model_map(c);
      chk("mem_addr",  c, 32'(mem_addr_o[c]),  32'(e.addr));
      chk("mem_rom",   c, 32'(mem_rom_o[c]),   32'(e.rom));
      chk("mem_we",    c, 32'(mem_we_o[c]),    32'(e.we));
      chk("mem_rd",    c, 32'(mem_rd_o[c]),    32'(e.rd));
      chk("vram_we",   c, 32'(vram_we_o[c]),   32'(e.vwe));
      chk("vram_addr", c, 32'(vram_addr_o[c]), 32'(e.vaddr));
      chk("shadow",    c, 32'(shadow_o[c]),    32'(m7[c][3]));
      chk("reg_7ffd",  c, 32'(r7_o[c]),        32'(m7[c]));
      chk("reg_1ffd",  c, 32'(r1_o[c]),        32'((cfg_p3[c] != 0) ? m1[c] : 8'h00));
      chk("locked",    c, 32'(lock_o[c]),      32'(mlock[c]));
    end
  endtask

  task automatic bus_idle();
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  // kind: 0 read, 1 write, 2 refresh, 3 idle
  task automatic mem_cycle(input logic [15:0] a, input int kind);
    @(negedge clk_cpu);
    bus_idle();
    A = a;
    din = 8'($urandom);
    nMREQ = (kind == 3);
    nRD   = !(kind == 0);
    nWR   = !(kind == 1);
    #1 check_all();
  endtask

  // kind: 0 OUT, 1 OUT-shaped cycle with M1 low, 2 IN
  task automatic io_cycle(input logic [15:0] a, input logic [7:0] d,
                          input int hold, input int kind);
    @(negedge clk_cpu);
    A = a; din = d; nMREQ = 1'b1; nIORQ = 1'b0;
    nWR = (kind == 2); nRD = (kind != 2); nM1 = (kind != 1);
    #1 check_all();
    @(posedge clk_cpu);
    if (kind == 0) model_write(a, d);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk_cpu);
      din = ~d;
      #1 check_all();
    end
    @(negedge clk_cpu);
    bus_idle();
    #1 check_all();
  endtask

  task automatic do_reset();
    @(negedge clk_cpu);
    #2 nRESET = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk_cpu);
    nRESET = 1'b1;
    #1 check_all();
  endtask

  initial begin
    tbl[0] = '{16'h0000, 0, 25'h0100000, 1'b1, 1'b0, 1'b1, 1'b0, 14'h0000};
    tbl[1] = '{16'h3FFF, 0, 25'h0103FFF, 1'b1, 1'b0, 1'b1, 1'b0, 14'h1FFF};
    tbl[2] = '{16'h4000, 0, 25'h0014000, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0000};
    tbl[3] = '{16'h8001, 0, 25'h0008001, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0001};
    tbl[4] = '{16'hC123, 0, 25'h0000123, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0123};
    tbl[5] = '{16'h0010, 1, 25'h0100010, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0010};
    tbl[6] = '{16'h4000, 1, 25'h0014000, 1'b0, 1'b1, 1'b0, 1'b1, 14'h0000};
    tbl[7] = '{16'h5FFF, 1, 25'h0015FFF, 1'b0, 1'b1, 1'b0, 1'b1, 14'h1FFF};
    tbl[8] = '{16'h6000, 1, 25'h0016000, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[9] = '{16'h4000, 2, 25'h0014000, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000};

    A = 16'h0000; din = 8'h00; bus_idle();
    nRESET = 1'b1;
    model_reset();
    #2 nRESET = 1'b0;
    repeat (2) @(negedge clk_cpu);
    nRESET = 1'b1;
    #1 check_all();

    // Post-reset map of the default 128K board against fixed vectors
    for (int i = 0; i < 10; i++) begin
      mem_cycle(tbl[i].a, tbl[i].kind);
      chk("tbl_addr",  0, 32'(mem_addr_o[0]),  32'(tbl[i].addr));
      chk("tbl_rom",   0, 32'(mem_rom_o[0]),   32'(tbl[i].rom));
      chk("tbl_we",    0, 32'(mem_we_o[0]),    32'(tbl[i].we));
      chk("tbl_rd",    0, 32'(mem_rd_o[0]),    32'(tbl[i].rd));
      chk("tbl_vwe",   0, 32'(vram_we_o[0]),   32'(tbl[i].vwe));
      chk("tbl_vaddr", 0, 32'(vram_addr_o[0]), 32'(tbl[i].vaddr));
    end

    // OUT held three cycles, data bus changes after the first edge
    io_cycle(16'h7FFD, 8'h13, 3, 0);
    chk("hold_reg7", 0, 32'(r7_o[0]), 32'h13);
    mem_cycle(16'hC000, 0);
    chk("page3_addr", 0, 32'(mem_addr_o[0]), 32'h000C000);
    mem_cycle(16'h0000, 0);
    chk("rom1_addr", 0, 32'(mem_addr_o[0]), 32'h0104000);

    // Lock, then ignored write, then async reset clears everything
    io_cycle(16'h7FFD, 8'h20, 1, 0);
    io_cycle(16'h7FFD, 8'h07, 1, 0);
    io_cycle(16'h1FFD, 8'h01, 1, 0);
    chk("lock_reg7", 0, 32'(r7_o[0]), 32'h20);
    chk("lock_bit",  1, 32'(lock_o[1]), 32'h1);
    chk("lock_reg1", 1, 32'(r1_o[1]), 32'h0);
    do_reset();
    chk("rst_lock", 0, 32'(lock_o[0]), 32'h0);
    chk("rst_reg7", 1, 32'(r7_o[1]), 32'h0);

    // Extended pages: 0xC5 -> page 29 on 32 pages, 13 on 16 pages
    io_cycle(16'h7FFD, 8'hC5, 1, 0);
    mem_cycle(16'hC000, 1);
    chk("p32_addr", 1, 32'(mem_addr_o[1]), 32'h0074000);
    chk("p32_vwe",  1, 32'(vram_we_o[1]),  32'h0);
    chk("p16_addr", 2, 32'(mem_addr_o[2]), 32'h0434000);

    // +3 special mode 11: RAM 4,7,6,3
    io_cycle(16'h1FFD, 8'h07, 1, 0);
    mem_cycle(16'h4000, 1);
    chk("sp_addr",  1, 32'(mem_addr_o[1]),  32'h001C000);
    chk("sp_vwe",   1, 32'(vram_we_o[1]),   32'h1);
    chk("sp_vaddr", 1, 32'(vram_addr_o[1]), 32'h2000);
    mem_cycle(16'h0000, 1);
    chk("sp_we0",   1, 32'(mem_we_o[1]),   32'h1);
    chk("sp_addr0", 1, 32'(mem_addr_o[1]), 32'h0010000);
    chk("sp_rom0",  1, 32'(mem_rom_o[1]),  32'h0);

    // Reset asserted across an OUT edge: reset wins
    @(negedge clk_cpu);
    nRESET = 1'b0;
    A = 16'h7FFD; din = 8'h17; nMREQ = 1'b1; nIORQ = 1'b0; nWR = 1'b0; nRD = 1'b1; nM1 = 1'b1;
    #1 model_reset();
    @(negedge clk_cpu);
    #1 check_all();
    bus_idle();
    #1 nRESET = 1'b1;
    @(negedge clk_cpu);
    #1 check_all();
    chk("rw_reg7", 0, 32'(r7_o[0]), 32'h0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      int r, sel, hold, kind;
      logic [15:0] a;
      logic [7:0]  d;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        do_reset();
      end else if (r < 25) begin
        mem_cycle(16'($urandom), $urandom_range(0, 3));
      end else begin
        sel = $urandom_range(0, 3);
        case (sel)
          0:       a = 16'h7FFD;
          1:       a = 16'h1FFD;
          2:       a = 16'h3FFD;
          default: a = 16'($urandom);
        endcase
        d = 8'($urandom);
        if ($urandom_range(0, 7) != 0) d[5] = 1'b0;
        hold = $urandom_range(1, 3);
        kind = $urandom_range(0, 5);
        kind = (kind < 4) ? 0 : kind - 3;
        io_cycle(a, d, hold, kind);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
